// File: rtl/insertion_sorter_rd.sv
// insertion_sorter_rd: systolic insertion sorter with head pop, runtime order mode and sticky overflow
module insertion_sorter_rd #(
    parameter int WID   = 9,
    parameter int DEP   = 11,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR,
    input  logic             VALID,
    input  logic [WID-1:0]   DIN,
    input  logic             MODE,
    input  logic             READ,
    output logic [WID-1:0]   DO,
    output logic             DO_VALID,
    output logic [CNT_W-1:0] N_CELLS,
    output logic             FULL,
    output logic             OVERFLOW
);
    localparam logic [CNT_W-1:0] DEP_C = CNT_W'(DEP);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    logic [WID-1:0]   cell_q [DEP];
    logic [WID-1:0]   cell_d [DEP];
    logic [WID-1:0]   base   [DEP];
    logic [CNT_W-1:0] n_q, n_d, base_n, ins;
    logic             mode_q, mode_d, ovf_q, ovf_d, dv_q, dv_d, full_q, full_d, pop;
    // pop the head first (if any), then insert DIN into what remains
    always_comb begin
        pop = READ && n_q != '0;
        base_n = pop ? n_q - ONE_C : n_q;
        for (int i = 0; i < DEP - 1; i++)
            base[i] = pop ? cell_q[i+1] : cell_q[i];
        base[DEP-1] = pop ? '0 : cell_q[DEP-1];
        ins = DEP_C;
        for (int i = DEP - 1; i >= 0; i--)
            if (CNT_W'(i) >= base_n || (mode_q ? DIN > base[i] : DIN < base[i]))
                ins = CNT_W'(i);
        cell_d[0] = VALID && ins == '0 ? DIN : base[0];
        for (int i = 1; i < DEP; i++)
            cell_d[i] = !VALID || CNT_W'(i) < ins ? base[i] : (CNT_W'(i) == ins ? DIN : base[i-1]);
        n_d = VALID && base_n != DEP_C ? base_n + ONE_C : base_n;
        ovf_d = ovf_q || (VALID && base_n == DEP_C);
        mode_d = n_q == '0 ? MODE : mode_q;
        full_d = n_d == DEP_C;
        dv_d = n_d != '0;
    end
    // state update; reset and clear both empty the list and drop any offered value
    always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
            for (int i = 0; i < DEP; i++)
                cell_q[i] <= '0;
            n_q    <= '0;
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
            dv_q   <= 1'b0;
            full_q <= 1'b0;
        end else begin
            cell_q <= cell_d;
            n_q    <= n_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
            dv_q   <= dv_d;
            full_q <= full_d;
        end
    end
    assign DO       = cell_q[0];
    assign DO_VALID = dv_q;
    assign N_CELLS  = n_q;
    assign FULL     = full_q;
    assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_insertion_sorter_rd.sv
// tb_insertion_sorter_rd: scoreboard bench for two sorter sizes against a queue-based model
module tb_insertion_sorter_rd;
    typedef struct packed {
        logic [8:0] d;
        logic       dv;
        logic [7:0] n;
        logic       full;
        logic       ovf;
    } exp_t;
    logic clk = 0, rst = 1, clear = 0, valid = 0, mode = 0, read = 0;
    logic [8:0] din = 0;
    logic [8:0] do_a, do_b;
    logic [7:0] n_a, n_b;
    logic dv_a, dv_b, full_a, full_b, ovf_a, ovf_b;
    int checks = 0, errors = 0;
    int lst [2][$];
    bit md [2];
    bit ovf [2];
    int deps [2] = '{11, 4};
    exp_t eq0 [$];
    exp_t eq1 [$];
    always #5 clk = ~clk;
    insertion_sorter_rd #(.WID(9), .DEP(11), .CNT_W(8)) u11 (
        .CLK(clk), .RST(rst), .CLEAR(clear), .VALID(valid), .DIN(din), .MODE(mode), .READ(read),
        .DO(do_a), .DO_VALID(dv_a), .N_CELLS(n_a), .FULL(full_a), .OVERFLOW(ovf_a));
    insertion_sorter_rd #(.WID(9), .DEP(4), .CNT_W(8)) u4 (
        .CLK(clk), .RST(rst), .CLEAR(clear), .VALID(valid), .DIN(din), .MODE(mode), .READ(read),
        .DO(do_b), .DO_VALID(dv_b), .N_CELLS(n_b), .FULL(full_b), .OVERFLOW(ovf_b));
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // sorted-list model: remove head, insert in order after equals, trim to capacity
    task automatic model_step(input int k, input bit r, input bit c, input bit v, input int d, input bit m, input bit rd);
        bit was_empty;
        int idx;
        exp_t e;
        was_empty = lst[k].size() == 0;
        if (r || c) begin
            lst[k].delete();
            ovf[k] = 0;
            md[k] = 0;
        end else begin
            if (rd && lst[k].size() > 0) void'(lst[k].pop_front());
            if (v) begin
                idx = lst[k].size();
                for (int j = 0; j < lst[k].size(); j++)
                    if (md[k] ? d > lst[k][j] : d < lst[k][j]) begin
                        idx = j;
                        break;
                    end
                lst[k].insert(idx, d);
                if (lst[k].size() > deps[k]) begin
                    void'(lst[k].pop_back());
                    ovf[k] = 1;
                end
            end
            if (was_empty) md[k] = m;
        end
        e.d = lst[k].size() > 0 ? 9'(lst[k][0]) : 9'd0;
        e.dv = lst[k].size() > 0;
        e.n = 8'(lst[k].size());
        e.full = lst[k].size() == deps[k];
        e.ovf = ovf[k];
        if (k == 0) eq0.push_back(e); else eq1.push_back(e);
    endtask
    task automatic cyc(input bit r, input bit c, input bit v, input int d, input bit m, input bit rd);
        rst = r; clear = c; valid = v; din = 9'(d); mode = m; read = rd;
        @(posedge clk);
        model_step(0, r, c, v, d, m, rd);
        model_step(1, r, c, v, d, m, rd);
        #1;
    endtask
    task automatic push(input int d, input bit m);
        cyc(0, 0, 1, d, m, 0);
    endtask
    task automatic pop(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask
    task automatic clr();
        cyc(0, 1, 0, 0, 0, 0);
    endtask
    // monitor: compare every registered output against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (eq0.size() > 0) begin
            e = eq0.pop_front();
            chk("u11.DO", do_a, e.d);
            chk("u11.DO_VALID", dv_a, e.dv);
            chk("u11.N_CELLS", n_a, e.n);
            chk("u11.FULL", full_a, e.full);
            chk("u11.OVERFLOW", ovf_a, e.ovf);
        end
        if (eq1.size() > 0) begin
            e = eq1.pop_front();
            chk("u4.DO", do_b, e.d);
            chk("u4.DO_VALID", dv_b, e.dv);
            chk("u4.N_CELLS", n_b, e.n);
            chk("u4.FULL", full_b, e.full);
            chk("u4.OVERFLOW", ovf_b, e.ovf);
        end
    end
    initial begin
        int vals [7] = '{55, 10, 77, 1, 60, 10, 255};
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 9, 1, 1);
        foreach (vals[i]) push(vals[i], 0);
        cyc(0, 0, 0, 0, 0, 0);
        pop(8);
        clr();
        push(55, 0); push(10, 0); push(77, 0); push(1, 0); push(60, 0); push(255, 0);
        cyc(0, 0, 1, 30, 0, 1);
        pop(5);
        cyc(0, 0, 1, 7, 0, 1);
        clr();
        push(5, 1); push(9, 0); push(2, 0);
        pop(4);
        clr();
        push(3, 0); push(3, 0);
        pop(2);
        push(6, 0);
        cyc(0, 1, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        push(20, 0); push(11, 0); push(40, 0);
        cyc(1, 0, 1, 5, 0, 0);
        push(8, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            int d;
            d = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 511);
            cyc($urandom_range(0, 127) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard drained", eq0.size() + eq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/insertion_sorter_rd.md
Name: insertion_sorter_rd

Overview:
Parametrised systolic insertion sorter with a pop interface, the successor to the fill-only sorter. It adds the following over that block:
- runtime ascending/descending mode;
- head readout with pop handshake;
- simultaneous push+pop;
- a defined full-list drop policy with a sticky overflow flag;
- a synchronous list clear.

It sits between hit/sample producers and readout logic that consumes values in sorted order.

Parameters:
WID, 9, data word width in bits
DEP, 11, number of sorting cells (list capacity), DEP >= 2
CNT_W, 8, width of N_CELLS; must satisfy 2**CNT_W > DEP

Ports:
CLK  in  1  single clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
CLEAR  in  1  synchronous list clear
VALID  in  1  push strobe, DIN inserted this cycle
DIN  in  WID  value to insert
MODE  in  1  0 = ascending (smallest at head), 1 = descending
READ  in  1  pop strobe, removes head this cycle
DO  out  WID  head-of-list value (cell 0), registered
DO_VALID  out  1  list non-empty
N_CELLS  out  CNT_W  number of occupied cells
FULL  out  1  N_CELLS == DEP
OVERFLOW  out  1  sticky: an element was discarded due to full list

Behaviour:
Reset and clear:
- RST: all cells value 0 and empty, N_CELLS=0, DO=0, DO_VALID=0, FULL=0, OVERFLOW=0, mode_r=0.
- Priority: RST > CLEAR > push/pop.
- CLEAR has the same effect as RST. DIN offered with CLEAR is dropped.
- Reset mid-operation discards all contents next cycle; no partial state remains.

Mode:
- mode_r <= MODE on every cycle in which N_CELLS==0. Frozen while the list is non-empty.
- "Precedes" means strict < for ascending, strict > for descending.
- Equal values insert after existing equals (stable).

Cells:
- Cells 0..DEP-1. Occupied cells are contiguous from cell 0 and always ordered per mode_r.

Push only (VALID=1, READ=0):
- DIN goes to the first cell whose value DIN precedes, or to the first empty cell.
- Cells from the insertion point onward shift one position toward DEP-1.
- N_CELLS+1.

Push when full:
- The element falling off cell DEP-1 is discarded.
- If DIN precedes no cell, DIN itself is discarded.
- N_CELLS stays DEP. OVERFLOW <= 1.

Pop only (READ=1, VALID=0, N_CELLS>0):
- Cell i <= cell i+1. Cell DEP-1 becomes empty, value 0.
- N_CELLS-1.
- READ on an empty list is ignored and has no flags.

Push+pop in the same cycle, non-empty list:
- Result is the sorted set of (contents minus head) plus DIN, in one cycle.
- N_CELLS unchanged. No overflow, even when full.
- If the list is empty, the READ is ignored and the push proceeds.

Outputs:
- Latency: an operation at edge k is visible on DO/N_CELLS/FULL/DO_VALID after edge k.
- DO = cell 0 value; it is 0 when empty.
- DO_VALID = (N_CELLS != 0). All outputs are registered.
- OVERFLOW is cleared only by RST or CLEAR.

Arithmetic:
- N_CELLS is never incremented past DEP or decremented below 0.
- Comparisons are unsigned, full WID bits.

Test Plan:
- DEP=11, MODE=0, push 55,10,77,1,60,10,255 on consecutive cycles, then VALID=0 -> cells 1,10,10,55,60,77,255; N_CELLS=7; DO=1; FULL=0; OVERFLOW=0.
- DEP=4, MODE=0, push 55,10,77,1 -> FULL=1. Push 60 -> list 1,10,55,60 (77 dropped), OVERFLOW=1. Push 255 -> list unchanged, N_CELLS=4.
- MODE=1 while empty, push 5,9,2; drive MODE=0 mid-fill -> list 9,5,2 (mode frozen). Three READs -> DO 9,5,2, then DO=0, DO_VALID=0. Fourth READ -> no change.
- DEP=4 full list 1,10,55,60: VALID=1, DIN=30 with READ=1 -> list 10,30,55,60, N_CELLS=4, OVERFLOW unchanged. READ+VALID on empty list with DIN=7 -> list 7, N_CELLS=1.
- Push 3,3 (equal) then pop -> stable order, DO=3 twice. Assert CLEAR with VALID=1, DIN=4 -> N_CELLS=0, OVERFLOW=0, 4 not stored.
- RST pulse mid-fill after 3 pushes -> next cycle all outputs at reset values. Subsequent push 8 -> DO=8, N_CELLS=1.
